// File: rtl/ploc_multilane_counter.sv
// Multi-entrance parking-lot occupancy counter: each lane has its own synchroniser,
// debouncer and direction FSM; lane events merge into one saturating count.
module ploc_multilane_counter #(
  parameter int LANES     = 2,
  parameter int CAP       = 99,
  parameter int CNT_W     = 7,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] sens_a,
  input  logic [LANES-1:0] sens_b,
  input  logic             clr_err,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] enter_pulse,
  output logic [LANES-1:0] exit_pulse,
  output logic             err_ovf,
  output logic             err_udf
);
  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int SUM_W = CNT_W + 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IN_A   = 3'd1;
  localparam logic [2:0] S_IN_AB  = 3'd2;
  localparam logic [2:0] S_IN_B   = 3'd3;
  localparam logic [2:0] S_OUT_B  = 3'd4;
  localparam logic [2:0] S_OUT_BA = 3'd5;
  localparam logic [2:0] S_OUT_A  = 3'd6;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [2:0] state_q, state_d;
    logic       enter_q, enter_d, exit_q, exit_d;

    // Bit 1 carries the outer beam (a), bit 0 the inner beam (b).
    assign raw = {sens_a[gi], sens_b[gi]};

    for (genvar bi = 0; bi < 2; bi++) begin : g_bit
      logic            meta_q, meta_d, sync_q, sync_d, lvl_q, lvl_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        meta_d = raw[bi];
        sync_d = meta_q;
        lvl_d  = lvl_q;
        cnt_d  = '0;
        if (sync_q != lvl_q) begin
          if (cnt_q == DB_W'(DB_CYCLES - 1)) lvl_d = sync_q;
          else                               cnt_d = cnt_q + DB_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          lvl_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          meta_q <= meta_d;
          sync_q <= sync_d;
          lvl_q  <= lvl_d;
          cnt_q  <= cnt_d;
        end
      end

      assign lvl[bi] = lvl_q;
    end

    always_comb begin
      state_d = state_q;
      enter_d = 1'b0;
      exit_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lvl == 2'b10)      state_d = S_IN_A;
          else if (lvl == 2'b01) state_d = S_OUT_B;
        end
        S_IN_A: begin
          if (lvl == 2'b11)      state_d = S_IN_AB;
          else if (lvl == 2'b00) state_d = S_IDLE;
        end
        S_IN_AB: begin
          if (lvl == 2'b01)      state_d = S_IN_B;
          else if (lvl == 2'b10) state_d = S_IN_A;
          else if (lvl == 2'b00) state_d = S_IDLE;
        end
        S_IN_B: begin
          if (lvl == 2'b00) begin
            state_d = S_IDLE;
            enter_d = 1'b1;
          end else if (lvl == 2'b11) begin
            state_d = S_IN_AB;
          end
        end
        S_OUT_B: begin
          if (lvl == 2'b11)      state_d = S_OUT_BA;
          else if (lvl == 2'b00) state_d = S_IDLE;
        end
        S_OUT_BA: begin
          if (lvl == 2'b10)      state_d = S_OUT_A;
          else if (lvl == 2'b01) state_d = S_OUT_B;
          else if (lvl == 2'b00) state_d = S_IDLE;
        end
        S_OUT_A: begin
          if (lvl == 2'b00) begin
            state_d = S_IDLE;
            exit_d  = 1'b1;
          end else if (lvl == 2'b11) begin
            state_d = S_OUT_BA;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        enter_q <= 1'b0;
        exit_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        enter_q <= enter_d;
        exit_q  <= exit_d;
      end
    end

    assign enter_pulse[gi] = enter_q;
    assign exit_pulse[gi]  = exit_q;
  end

  logic [CNT_W-1:0]        count_q, count_d;
  logic [3:0]              tens_q, tens_d, ones_q, ones_d;
  logic                    full_q, full_d, empty_q, empty_d;
  logic                    err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
  logic [3:0]              e_cnt, x_cnt;
  logic signed [SUM_W-1:0] sum;

  // Entries and exits in one cycle net out before saturation is applied.
  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      e_cnt = e_cnt + 4'(enter_pulse[i]);
      x_cnt = x_cnt + 4'(exit_pulse[i]);
    end
    sum = $signed(SUM_W'(count_q)) + $signed(SUM_W'(e_cnt)) - $signed(SUM_W'(x_cnt));
    err_ovf_d = err_ovf_q & ~clr_err;
    err_udf_d = err_udf_q & ~clr_err;
    if (sum[SUM_W-1]) begin
      count_d   = '0;
      err_udf_d = 1'b1;
    end else if (sum > $signed(SUM_W'(CAP))) begin
      count_d   = CNT_W'(CAP);
      err_ovf_d = 1'b1;
    end else begin
      count_d = CNT_W'(sum);
    end
    full_d  = (count_d == CNT_W'(CAP));
    empty_d = (count_d == '0);
    tens_d  = 4'(count_d / CNT_W'(10));
    ones_d  = 4'(count_d % CNT_W'(10));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign count    = count_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;
endmodule

// File: tb/tb_ploc_multilane_counter.sv
// Bench for ploc_multilane_counter: sensor levels held per phase, checked against a
// lane "track position" model and an arithmetic occupancy model.
module tb_ploc_multilane_counter;
  localparam int LANES     = 2;
  localparam int CAP       = 99;
  localparam int CNT_W     = 7;
  localparam int DB_CYCLES = 16;
  localparam int HOLD      = 40;
  localparam int LAT       = DB_CYCLES + 3;  // input change to registered lane pulse

  logic             clk;
  logic             reset;
  logic [LANES-1:0] sens_a;
  logic [LANES-1:0] sens_b;
  logic             clr_err;
  logic [CNT_W-1:0] count;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;
  logic             full;
  logic             empty;
  logic [LANES-1:0] enter_pulse;
  logic [LANES-1:0] exit_pulse;
  logic             err_ovf;
  logic             err_udf;

  ploc_multilane_counter #(
    .LANES(LANES), .CAP(CAP), .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b), .clr_err(clr_err),
    .count(count), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: direction 0 none, 1 entering, 2 exiting; position 1..3 along the path.
  int m_dir [LANES];
  int m_pos [LANES];
  int m_count;
  bit m_ovf, m_udf;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int track_pos(input int dir, input logic [1:0] p);
    if (p == 2'b11) return 2;
    if ((dir == 1) == (p == 2'b10)) return 1;
    return 3;
  endfunction

  task automatic model_lane(input int i, input logic [1:0] p, output bit ent, output bit ext);
    int q;
    ent = 1'b0;
    ext = 1'b0;
    if (p == 2'b00) begin
      if (m_dir[i] != 0 && m_pos[i] == 3) begin
        ent = (m_dir[i] == 1);
        ext = (m_dir[i] == 2);
      end
      m_dir[i] = 0;
      m_pos[i] = 0;
    end else if (m_dir[i] == 0) begin
      if (p == 2'b10)      begin m_dir[i] = 1; m_pos[i] = 1; end
      else if (p == 2'b01) begin m_dir[i] = 2; m_pos[i] = 1; end
    end else begin
      q = track_pos(m_dir[i], p);
      if (q - m_pos[i] <= 1 && m_pos[i] - q <= 1) m_pos[i] = q;
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      m_dir[i] = 0;
      m_pos[i] = 0;
    end
  endtask

  task automatic check_outputs();
    check("count", count, m_count);
    check("full", full, int'(m_count == CAP));
    check("empty", empty, int'(m_count == 0));
    check("bcd_tens", bcd_tens, m_count / 10);
    check("bcd_ones", bcd_ones, m_count % 10);
    check("err_ovf", err_ovf, m_ovf);
    check("err_udf", err_udf, m_udf);
  endtask

  // Hold one sensor pattern for HOLD cycles; optional short glitch and error clear.
  task automatic apply_phase(input logic [LANES-1:0] a_v, input logic [LANES-1:0] b_v,
                             input bit glitch, input bit clr);
    int old_count, e_tot, x_tot, n, gl_lane, gl_len;
    int exp_e [LANES];
    int exp_x [LANES];
    int obs_e [LANES];
    int obs_x [LANES];
    bit pe, px;
    old_count = m_count;
    e_tot = 0;
    x_tot = 0;
    for (int i = 0; i < LANES; i++) begin
      model_lane(i, {a_v[i], b_v[i]}, pe, px);
      exp_e[i] = int'(pe);
      exp_x[i] = int'(px);
      e_tot += int'(pe);
      x_tot += int'(px);
      obs_e[i] = 0;
      obs_x[i] = 0;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    n = m_count + e_tot - x_tot;
    if (n > CAP)    begin m_count = CAP; m_ovf = 1'b1; end
    else if (n < 0) begin m_count = 0;   m_udf = 1'b1; end
    else            m_count = n;

    gl_lane = int'($urandom_range(LANES - 1, 0));
    gl_len  = int'($urandom_range(12, 1));
    sens_a = a_v;
    sens_b = b_v;
    for (int c = 1; c <= HOLD; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < LANES; i++) begin
        if (enter_pulse[i]) begin obs_e[i]++; check("enter_lat", c, LAT); end
        if (exit_pulse[i])  begin obs_x[i]++; check("exit_lat", c, LAT); end
      end
      if (c == LAT) check("count_before", count, old_count);
      if (clr && c == LAT) clr_err = 1'b1;
      if (clr && c == LAT + 1) clr_err = 1'b0;
      if (glitch && c == LAT + 3) sens_b[gl_lane] = ~b_v[gl_lane];
      if (glitch && c == LAT + 3 + gl_len) sens_b[gl_lane] = b_v[gl_lane];
    end
    for (int i = 0; i < LANES; i++) begin
      check("enter_count", obs_e[i], exp_e[i]);
      check("exit_count", obs_x[i], exp_x[i]);
    end
    check_outputs();
  endtask

  // Full entry walk on lanes in ent_m and full exit walk on lanes in ext_m, in lockstep.
  task automatic gesture(input logic [LANES-1:0] ent_m, input logic [LANES-1:0] ext_m);
    logic [1:0] ep [4];
    logic [1:0] xp [4];
    logic [LANES-1:0] a_v, b_v;
    ep = '{2'b10, 2'b11, 2'b01, 2'b00};
    xp = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) begin
        a_v[i] = (ent_m[i] & ep[k][1]) | (ext_m[i] & xp[k][1]);
        b_v[i] = (ent_m[i] & ep[k][0]) | (ext_m[i] & xp[k][0]);
      end
      apply_phase(a_v, b_v, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset_enter", enter_pulse, 0);
    check("reset_exit", exit_pulse, 0);
    check_outputs();
    apply_phase(sens_a, sens_b, 1'b0, 1'b0);
  endtask

  initial begin
    sens_a = '0;
    sens_b = '0;
    clr_err = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_enter", enter_pulse, 0);
    check("reset_exit", exit_pulse, 0);
    check_outputs();
    reset = 1'b0;

    // Single entry on lane 0, then exits on lane 1 down to and past zero.
    apply_phase(2'b00, 2'b00, 1'b0, 1'b0);
    gesture(2'b01, 2'b00);
    gesture(2'b00, 2'b10);
    gesture(2'b00, 2'b10);
    apply_phase(2'b00, 2'b00, 1'b0, 1'b1);

    // Aborted entry with filtered glitches, then a clean entry from IDLE.
    apply_phase(2'b01, 2'b00, 1'b0, 1'b0);
    apply_phase(2'b01, 2'b01, 1'b1, 1'b0);
    apply_phase(2'b01, 2'b00, 1'b0, 1'b0);
    apply_phase(2'b00, 2'b00, 1'b1, 1'b0);
    gesture(2'b01, 2'b00);

    // Simultaneous entry and exit at count 5.
    repeat (2) gesture(2'b11, 2'b00);
    gesture(2'b01, 2'b10);

    // Reset in the middle of an entry at count 42; the tail of the walk must not count.
    repeat (18) gesture(2'b11, 2'b00);
    gesture(2'b01, 2'b00);
    apply_phase(2'b01, 2'b00, 1'b0, 1'b0);
    apply_phase(2'b01, 2'b01, 1'b0, 1'b0);
    check("count_42", count, 42);
    do_reset();
    apply_phase(2'b00, 2'b01, 1'b0, 1'b0);
    apply_phase(2'b00, 2'b00, 1'b0, 1'b0);

    // Fill to capacity, overflow by two, clear, then net-zero traffic at capacity.
    repeat (49) gesture(2'b11, 2'b00);
    gesture(2'b01, 2'b00);
    gesture(2'b11, 2'b00);
    apply_phase(2'b00, 2'b00, 1'b0, 1'b1);
    gesture(2'b01, 2'b10);

    // Random sensor patterns with occasional glitches and error clears.
    for (int r = 0; r < 150; r++) begin
      apply_phase(LANES'($urandom), LANES'($urandom),
                  ($urandom_range(3, 0) == 0), ($urandom_range(9, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
